alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the pipeline's combinational ALU.
- Single-cycle ops: adds AND/XOR/NOR/SLT/SLTU and a correct arithmetic right shift for any shift amount.
- Multi-cycle ops: iterative unsigned multiply and divide into HI/LO registers.
- Sits in EX. The pipeline stalls on busy and captures c on out_valid.

---
 rtl/alu_mc.sv | 213 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - EX-stage ALU: single-cycle ops plus iterative MULTU/DIVU into HI/LO
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5,
   parameter int CW    = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic             out_valid,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   localparam logic [3:0] OP_ADDU  = 4'd0;
   localparam logic [3:0] OP_SUBU  = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_SLL   = 4'd3;
   localparam logic [3:0] OP_SRL   = 4'd4;
   localparam logic [3:0] OP_SRA   = 4'd5;
   localparam logic [3:0] OP_LUI   = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_XOR   = 4'd8;
   localparam logic [3:0] OP_NOR   = 4'd9;
   localparam logic [3:0] OP_SLT   = 4'd10;
   localparam logic [3:0] OP_SLTU  = 4'd11;
   localparam logic [3:0] OP_MULTU = 4'd12;
   localparam logic [3:0] OP_DIVU  = 4'd13;

   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_done;
   logic [WIDTH-1:0]     r_c;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_out_valid;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH:0]       r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_dvsr;

   logic                 w_busy;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_b_nz;
   logic [WIDTH-1:0]     w_result;
   logic [WIDTH-1:0]     w_mul_add;
   logic [WIDTH:0]       w_mul_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH+1:0]     w_div_shift;
   logic [WIDTH+1:0]     w_div_trial;
   logic                 w_div_borrow;
   logic [WIDTH:0]       w_rem_next;
   logic [WIDTH-1:0]     w_quo_next;

   assign w_busy    = (r_state != S_IDLE);
   assign in_ready  = ~w_busy;
   assign busy      = w_busy;
   assign c         = r_c;
   assign hi        = r_hi;
   assign lo        = r_lo;
   assign out_valid = r_out_valid;

   assign w_accept = in_valid & ~w_busy & ~flush;
   assign w_last   = (r_cnt == CNT_ONE);
   assign w_b_nz   = |b;

   // Multiplier sits in the low half of r_acc and is consumed LSB-first as the product shifts in.
   assign w_mul_add  = r_acc[0] ? r_mcand : '0;
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_add};
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring divide: the extra top bit of the trial difference is the borrow.
   assign w_div_shift  = {r_rem, r_quo[WIDTH-1]};
   assign w_div_trial  = w_div_shift - {2'b00, r_dvsr};
   assign w_div_borrow = w_div_trial[WIDTH+1];
   assign w_rem_next   = w_div_borrow ? w_div_shift[WIDTH:0] : w_div_trial[WIDTH:0];
   assign w_quo_next   = {r_quo[WIDTH-2:0], ~w_div_borrow};

   always_comb begin
      w_result = '0;
      case (alu_op)
         OP_ADDU: w_result = a + b;
         OP_SUBU: w_result = a - b;
         OP_OR:   w_result = a | b;
         OP_SLL:  w_result = b << a[SHW-1:0];
         OP_SRL:  w_result = b >> a[SHW-1:0];
         OP_SRA:  w_result = $unsigned($signed(b) >>> a[SHW-1:0]);
         OP_LUI:  w_result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         OP_AND:  w_result = a & b;
         OP_XOR:  w_result = a ^ b;
         OP_NOR:  w_result = ~(a | b);
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (a < b)};
         default: w_result = '0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && alu_op == OP_MULTU)
               w_state_next = S_MUL;
            else if (w_accept && alu_op == OP_DIVU && w_b_nz)
               w_state_next = S_DIV;
         end
         S_MUL, S_DIV: begin
            if (flush) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_IDLE;
               w_done       = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c         <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvsr      <= '0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (alu_op == OP_MULTU) begin
                     r_acc   <= {{WIDTH{1'b0}}, b};
                     r_mcand <= a;
                     r_cnt   <= CNT_FULL;
                  end else if (alu_op == OP_DIVU && w_b_nz) begin
                     r_rem  <= '0;
                     r_quo  <= a;
                     r_dvsr <= b;
                     r_cnt  <= CNT_FULL;
                  end else if (alu_op == OP_DIVU) begin
                     r_lo        <= '1;
                     r_hi        <= a;
                     r_c         <= '1;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_c         <= w_result;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  r_cnt <= '0;
               end else begin
                  r_acc <= w_mul_next;
                  r_cnt <= r_cnt - CNT_ONE;
                  if (w_done) begin
                     r_hi        <= w_mul_next[2*WIDTH-1:WIDTH];
                     r_lo        <= w_mul_next[WIDTH-1:0];
                     r_c         <= w_mul_next[WIDTH-1:0];
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_DIV: begin
               if (flush) begin
                  r_cnt <= '0;
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
                  r_cnt <= r_cnt - CNT_ONE;
                  if (w_done) begin
                     r_hi        <= w_rem_next[WIDTH-1:0];
                     r_lo        <= w_quo_next;
                     r_c         <= w_quo_next;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed vector bench for alu_mc at WIDTH=32 and WIDTH=16
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [3:0]  alu_op;
   logic [31:0] a, b;
   logic        in_ready, out_valid, busy;
   logic [31:0] c, hi, lo;

   logic        in_valid16;
   logic [3:0]  alu_op16;
   logic [15:0] a16, b16;
   logic        in_ready16, out_valid16, busy16;
   logic [15:0] c16, hi16, lo16;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(32), .SHW(5), .CW(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .alu_op(alu_op), .a(a), .b(b), .c(c), .out_valid(out_valid), .busy(busy),
      .hi(hi), .lo(lo)
   );

   alu_mc #(.WIDTH(16), .SHW(4), .CW(5)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .flush(flush),
      .alu_op(alu_op16), .a(a16), .b(b16), .c(c16), .out_valid(out_valid16), .busy(busy16),
      .hi(hi16), .lo(lo16)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_mc(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit b2b);
      int k;
      bit early_ov;
      @(negedge clk);
      alu_op = op; a = ia; b = ib; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("mc_in_ready_low", {63'd0, in_ready}, 64'd0);
      k = 0;
      early_ov = 1'b0;
      while (busy && k < 100) begin
         k++;
         if (out_valid) early_ov = 1'b1;
         in_valid = k[0];
         alu_op = 4'd0; a = $urandom; b = $urandom;
         @(posedge clk); #1;
      end
      if (b2b) begin
         alu_op = 4'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      end else begin
         in_valid = 1'b0;
      end
      chk("mc_busy_cycles", 64'(k), 64'd32);
      chk("mc_no_early_ov", {63'd0, early_ov}, 64'd0);
      chk("mc_out_valid", {63'd0, out_valid}, 64'd1);
      chk("mc_c", {32'd0, c}, {32'd0, exp_lo});
      chk("mc_hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("mc_lo", {32'd0, lo}, {32'd0, exp_lo});
      if (b2b) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
         chk("b2b_c_sum", {32'd0, c}, 64'd7);
         chk("b2b_hi_hold", {32'd0, hi}, {32'd0, exp_hi});
         chk("b2b_lo_hold", {32'd0, lo}, {32'd0, exp_lo});
      end
      @(posedge clk); #1;
      chk("mc_ov_drop", {63'd0, out_valid}, 64'd0);
   endtask

   task automatic run_mc16(input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                           input logic [15:0] exp_hi, input logic [15:0] exp_lo);
      int k;
      @(negedge clk);
      alu_op16 = op; a16 = ia; b16 = ib; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      k = 0;
      while (busy16 && k < 100) begin
         k++;
         @(posedge clk); #1;
      end
      chk("w16_busy_cycles", 64'(k), 64'd16);
      chk("w16_out_valid", {63'd0, out_valid16}, 64'd1);
      chk("w16_hi", {48'd0, hi16}, {48'd0, exp_hi});
      chk("w16_lo", {48'd0, lo16}, {48'd0, exp_lo});
      chk("w16_c", {48'd0, c16}, {48'd0, exp_lo});
   endtask

   initial begin
      bit seen_ov;
      vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[1]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      vecs[2]  = '{4'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
      vecs[3]  = '{4'd7,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
      vecs[4]  = '{4'd8,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F};
      vecs[5]  = '{4'd9,  32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0};
      vecs[6]  = '{4'd3,  32'h0000_0004, 32'h0000_0001, 32'h0000_0010};
      vecs[7]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
      vecs[8]  = '{4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[9]  = '{4'd5,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
      vecs[10] = '{4'd5,  32'h0000_0001, 32'h8000_0000, 32'hC000_0000};
      vecs[11] = '{4'd5,  32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF};
      vecs[12] = '{4'd5,  32'h0000_0004, 32'h7FFF_FFFF, 32'h07FF_FFFF};
      vecs[13] = '{4'd5,  32'hFFFF_FFE1, 32'h8000_0000, 32'hC000_0000};
      vecs[14] = '{4'd4,  32'h0000_001F, 32'h8000_0000, 32'h0000_0001};
      vecs[15] = '{4'd6,  32'h0000_0000, 32'h0000_ABCD, 32'hABCD_0000};
      vecs[16] = '{4'd6,  32'h0000_0000, 32'h1234_ABCD, 32'hABCD_0000};
      vecs[17] = '{4'd10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[18] = '{4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};
      vecs[19] = '{4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = 4'd0; a = '0; b = '0;
      in_valid16 = 1'b0; alu_op16 = 4'd0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_c", {32'd0, c}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         alu_op = vecs[i].op; a = vecs[i].va; b = vecs[i].vb; in_valid = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("vec%0d_c", i), {32'd0, c}, {32'd0, vecs[i].exp});
         chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd0);
         chk($sformatf("vec%0d_hilo", i), {hi, lo}, 64'd0);
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("single_ov_drop", {63'd0, out_valid}, 64'd0);

      run_mc(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_mc(4'd13, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

      @(negedge clk);
      alu_op = 4'd13; a = 32'd5; b = 32'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("div0_busy", {63'd0, busy}, 64'd0);
      chk("div0_out_valid", {63'd0, out_valid}, 64'd1);
      chk("div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
      chk("div0_hi", {32'd0, hi}, 64'd5);
      chk("div0_c", {32'd0, c}, 64'h0000_0000_FFFF_FFFF);
      @(posedge clk); #1;
      chk("div0_busy_after", {63'd0, busy}, 64'd0);

      @(negedge clk);
      alu_op = 4'd12; a = 32'd3; b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("flush_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy_drop", {63'd0, busy}, 64'd0);
      chk("flush_no_ov", {63'd0, out_valid}, 64'd0);
      chk("flush_hi_hold", {32'd0, hi}, 64'd5);
      chk("flush_lo_hold", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
      chk("flush_c_hold", {32'd0, c}, 64'h0000_0000_FFFF_FFFF);
      seen_ov = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(posedge clk); #1;
         if (out_valid) seen_ov = 1'b1;
      end
      chk("flush_no_late_ov", {63'd0, seen_ov}, 64'd0);

      @(negedge clk);
      alu_op = 4'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("idle_flush_pre_c", {32'd0, c}, 64'd3);
      a = 32'd10; b = 32'd10; flush = 1'b1;
      @(posedge clk); #1;
      chk("idle_flush_ov", {63'd0, out_valid}, 64'd0);
      chk("idle_flush_c", {32'd0, c}, 64'd3);
      flush = 1'b0; in_valid = 1'b0;

      @(negedge clk);
      alu_op = 4'd13; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_c", {32'd0, c}, 64'd0);
      chk("rst_mid_hi", {32'd0, hi}, 64'd0);
      chk("rst_mid_lo", {32'd0, lo}, 64'd0);
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_ov", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_ov = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(posedge clk); #1;
         if (out_valid) seen_ov = 1'b1;
      end
      chk("rst_mid_no_ov", {63'd0, seen_ov}, 64'd0);

      @(negedge clk);
      alu_op16 = 4'd5; a16 = 16'd15; b16 = 16'h8000; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      chk("w16_sra_c", {48'd0, c16}, 64'h0000_0000_0000_FFFF);
      chk("w16_sra_ov", {63'd0, out_valid16}, 64'd1);
      run_mc16(4'd12, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
      run_mc16(4'd13, 16'd100, 16'd7, 16'd2, 16'd14);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
